// File: rtl/cp0_int_unit.sv
// CP0 interrupt/exception unit: Status/Cause/EPC registers plus entry/return redirect sequencing.
// Optional macro IRQ_EDGE_LATCH_EN: sticky, rising-edge-latched pending bits cleared by writing 1 to Cause.
module cp0_int_unit #(
    parameter int                 NUM_IRQ    = 4,
    parameter logic [31:0]        VEC_ADDR   = 32'h0000_0008,
    parameter logic [NUM_IRQ-1:0] RESET_MASK = {NUM_IRQ{1'b1}}
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic               exc_req_i,
    input  logic [1:0]         exc_code_i,
    input  logic [31:0]        epc_i,
    input  logic               pc_ifwrite_i,
    input  logic               eret_i,
    input  logic               mtc0_we_i,
    input  logic [4:0]         c0_addr_i,
    input  logic [31:0]        mtc0_data_i,
    output logic [31:0]        mfc0_data_o,
    output logic               redirect_o,
    output logic [31:0]        redirect_pc_o,
    output logic               flush_o,
    output logic               int_taken_o,
    output logic [2:0]         int_id_o
);

    localparam logic [4:0] ADDR_STATUS = 5'd12;
    localparam logic [4:0] ADDR_CAUSE  = 5'd13;
    localparam logic [4:0] ADDR_EPC    = 5'd14;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TAKE    = 2'd1,
        HANDLER = 2'd2,
        RETURN  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic               r_ie;
    logic               r_exl;
    logic [NUM_IRQ-1:0] r_mask;
    logic [1:0]         r_code;
    logic [31:0]        r_epc;
    logic               r_entry_int;
    logic [2:0]         r_int_id;
    logic               r_hold_vld;
    logic [1:0]         r_hold_code;
    logic [31:0]        r_hold_epc;

    logic [NUM_IRQ-1:0] w_pending;
    logic [NUM_IRQ-1:0] w_masked;
    logic [2:0]         w_int_id;
    logic               w_accept;
    logic               w_exc_take;
    logic [1:0]         w_exc_code;
    logic [31:0]        w_exc_epc;
    logic               w_int_take;
    logic               w_entry;
    logic               w_eret_take;
    logic               w_hold_load;
    logic               w_status_we;
    logic               w_epc_we;
    logic               w_unused;

    assign w_status_we = mtc0_we_i && (c0_addr_i == ADDR_STATUS);
    assign w_epc_we    = mtc0_we_i && (c0_addr_i == ADDR_EPC);
    assign w_unused    = ^{mtc0_data_i[31:8+NUM_IRQ], mtc0_data_i[7:2]};

`ifdef IRQ_EDGE_LATCH_EN
    logic [NUM_IRQ-1:0] r_irq_q;
    logic [NUM_IRQ-1:0] r_pending;
    logic [NUM_IRQ-1:0] w_clr;

    assign w_clr = (mtc0_we_i && (c0_addr_i == ADDR_CAUSE)) ? mtc0_data_i[8 +: NUM_IRQ] : '0;

    // A new rising edge beats a same-cycle software clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_irq_q   <= '0;
            r_pending <= '0;
        end else begin
            r_irq_q   <= irq_i;
            r_pending <= (r_pending & ~w_clr) | (irq_i & ~r_irq_q);
        end
    end

    assign w_pending = r_pending;
`else
    assign w_pending = rst ? '0 : irq_i;
`endif

    assign w_masked = w_pending & r_mask;

    always_comb begin
        w_int_id = 3'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_masked[i]) begin
                w_int_id = 3'(i);
            end
        end
    end

    // Entries are only accepted outside the redirect cycles; an older held exception goes first.
    always_comb begin
        w_accept    = (r_state == IDLE) || (r_state == HANDLER);
        w_exc_take  = w_accept && (r_hold_vld || exc_req_i);
        w_exc_code  = r_hold_vld ? r_hold_code : exc_code_i;
        w_exc_epc   = r_hold_vld ? r_hold_epc : epc_i;
        w_int_take  = w_accept && !w_exc_take && r_ie && !r_exl && pc_ifwrite_i && (|w_masked);
        w_entry     = w_exc_take || w_int_take;
        w_eret_take = (r_state == HANDLER) && eret_i && !w_entry;
        w_hold_load = exc_req_i && (!w_accept || r_hold_vld);
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_entry) begin
                    w_next_state = TAKE;
                end
            end
            TAKE: begin
                w_next_state = HANDLER;
            end
            HANDLER: begin
                if (w_entry) begin
                    w_next_state = TAKE;
                end else if (w_eret_take) begin
                    w_next_state = RETURN;
                end
            end
            RETURN: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Entry and eret own EXL; a coincident mtc0 still updates IE and the mask.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ie   <= 1'b0;
            r_exl  <= 1'b0;
            r_mask <= RESET_MASK;
        end else begin
            if (w_status_we) begin
                r_ie   <= mtc0_data_i[0];
                r_mask <= mtc0_data_i[8 +: NUM_IRQ];
            end
            if (w_entry) begin
                r_exl <= 1'b1;
            end else if (w_eret_take) begin
                r_exl <= 1'b0;
            end else if (w_status_we) begin
                r_exl <= mtc0_data_i[1];
            end
        end
    end

    // A nested exception (EXL already set) keeps the original return address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_code      <= 2'b00;
            r_epc       <= 32'd0;
            r_entry_int <= 1'b0;
            r_int_id    <= 3'd0;
        end else begin
            if (w_exc_take) begin
                r_code <= w_exc_code;
            end else if (w_int_take) begin
                r_code <= 2'b00;
            end
            if (w_int_take) begin
                r_epc <= epc_i;
            end else if (w_exc_take && !r_exl) begin
                r_epc <= w_exc_epc;
            end else if (w_epc_we) begin
                r_epc <= mtc0_data_i;
            end
            if (w_entry) begin
                r_entry_int <= w_int_take;
                r_int_id    <= w_int_take ? w_int_id : 3'd0;
            end
        end
    end

    // One-deep buffer is enough: the redirect flush keeps exception requests from arriving back to back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_vld  <= 1'b0;
            r_hold_code <= 2'b00;
            r_hold_epc  <= 32'd0;
        end else if (w_hold_load) begin
            r_hold_vld  <= 1'b1;
            r_hold_code <= exc_code_i;
            r_hold_epc  <= epc_i;
        end else if (w_exc_take && r_hold_vld) begin
            r_hold_vld <= 1'b0;
        end
    end

    always_comb begin
        mfc0_data_o = 32'd0;
        case (c0_addr_i)
            ADDR_STATUS: begin
                mfc0_data_o[0]             = r_ie;
                mfc0_data_o[1]             = r_exl;
                mfc0_data_o[8 +: NUM_IRQ]  = r_mask;
            end
            ADDR_CAUSE: begin
                mfc0_data_o[3:2]           = r_code;
                mfc0_data_o[8 +: NUM_IRQ]  = w_pending;
            end
            ADDR_EPC: begin
                mfc0_data_o = r_epc;
            end
            default: begin
                mfc0_data_o = 32'd0;
            end
        endcase
    end

    always_comb begin
        redirect_o    = (r_state == TAKE) || (r_state == RETURN);
        flush_o       = redirect_o;
        redirect_pc_o = 32'd0;
        if (r_state == TAKE) begin
            redirect_pc_o = VEC_ADDR;
        end else if (r_state == RETURN) begin
            redirect_pc_o = r_epc;
        end
        int_taken_o = (r_state == TAKE) && r_entry_int;
        int_id_o    = int_taken_o ? r_int_id : 3'd0;
    end

endmodule

// File: tb/tb_cp0_int_unit.sv
// Self-checking bench for cp0_int_unit: directed scenarios then random traffic against a behavioural model.
// Honours IRQ_EDGE_LATCH_EN the same way as the design when it is defined for both.
module tb_cp0_int_unit;

    localparam int          NIRQ = 4;
    localparam logic [31:0] VEC  = 32'h0000_0008;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  irqIn;
    logic        excReq;
    logic [1:0]  excCode;
    logic [31:0] epcIn;
    logic        pcIfWrite;
    logic        eretIn;
    logic        mtc0We;
    logic [4:0]  c0Addr;
    logic [31:0] mtc0Data;
    logic [31:0] mfc0Data;
    logic        redirect;
    logic [31:0] redirectPc;
    logic        flush;
    logic        intTaken;
    logic [2:0]  intId;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    always #5 clk = ~clk;

    cp0_int_unit #(
        .NUM_IRQ   (NIRQ),
        .VEC_ADDR  (VEC),
        .RESET_MASK(4'hF)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .irq_i        (irqIn),
        .exc_req_i    (excReq),
        .exc_code_i   (excCode),
        .epc_i        (epcIn),
        .pc_ifwrite_i (pcIfWrite),
        .eret_i       (eretIn),
        .mtc0_we_i    (mtc0We),
        .c0_addr_i    (c0Addr),
        .mtc0_data_i  (mtc0Data),
        .mfc0_data_o  (mfc0Data),
        .redirect_o   (redirect),
        .redirect_pc_o(redirectPc),
        .flush_o      (flush),
        .int_taken_o  (intTaken),
        .int_id_o     (intId)
    );

    // Model: phase 0 running, 1 vectoring, 2 in handler, 3 returning; exceptions that cannot be
    // accepted yet wait in a queue.
    typedef struct {
        bit [1:0]  code;
        bit [31:0] epc;
    } excReq_t;

    int        mPhase;
    bit        mIe;
    bit        mExl;
    bit [3:0]  mMask;
    bit [3:0]  mPend;
    bit [3:0]  mIrqPrev;
    bit [1:0]  mCode;
    bit [31:0] mEpc;
    bit        mEntryInt;
    int        mIntId;
    excReq_t   mHeld[$];

    task automatic modelReset();
        mPhase    = 0;
        mIe       = 1'b0;
        mExl      = 1'b0;
        mMask     = 4'hF;
        mPend     = 4'h0;
        mIrqPrev  = 4'h0;
        mCode     = 2'b00;
        mEpc      = 32'd0;
        mEntryInt = 1'b0;
        mIntId    = 0;
        mHeld.delete();
    endtask

    function automatic bit [3:0] modelPending(input bit [3:0] irq);
`ifdef IRQ_EDGE_LATCH_EN
        return mPend;
`else
        return irq;
`endif
    endfunction

    function automatic bit [31:0] modelRead(input bit [4:0] addr, input bit [3:0] irq);
        case (addr)
            5'd12:   return {20'd0, mMask, 6'd0, mExl, mIe};
            5'd13:   return {20'd0, modelPending(irq), 4'd0, mCode, 2'd0};
            5'd14:   return mEpc;
            default: return 32'd0;
        endcase
    endfunction

    task automatic modelStep(input bit [3:0] irq, input bit exc, input bit [1:0] code,
                             input bit [31:0] epc, input bit pcw, input bit eret,
                             input bit we, input bit [4:0] addr, input bit [31:0] data);
        bit       entered   = 1'b0;
        bit       eretDone  = 1'b0;
        bit       wroteEpc  = 1'b0;
        bit       found     = 1'b0;
        bit [3:0] live      = modelPending(irq) & mMask;
        excReq_t  incoming;
        excReq_t  chosen;
        incoming.code = code;
        incoming.epc  = epc;
        if (mPhase == 0 || mPhase == 2) begin
            if (mHeld.size() > 0 || exc) begin
                if (mHeld.size() > 0) begin
                    chosen = mHeld.pop_front();
                    if (exc) mHeld.push_back(incoming);
                end else begin
                    chosen = incoming;
                end
                if (!mExl) begin
                    mEpc     = chosen.epc;
                    wroteEpc = 1'b1;
                end
                mCode     = chosen.code;
                mEntryInt = 1'b0;
                mIntId    = 0;
                entered   = 1'b1;
            end else if (mIe && !mExl && pcw && live != 4'h0) begin
                for (int i = 0; i < 4; i++) begin
                    if (live[i] && !found) begin
                        mIntId = i;
                        found  = 1'b1;
                    end
                end
                mEpc      = epc;
                wroteEpc  = 1'b1;
                mCode     = 2'b00;
                mEntryInt = 1'b1;
                entered   = 1'b1;
            end else if (mPhase == 2 && eret) begin
                eretDone = 1'b1;
            end
        end else if (exc) begin
            mHeld.push_back(incoming);
        end
        if (we && addr == 5'd12) begin
            mIe   = data[0];
            mMask = data[11:8];
            if (!entered && !eretDone) mExl = data[1];
        end
        if (we && addr == 5'd14 && !wroteEpc) mEpc = data;
        if (entered) mExl = 1'b1;
        else if (eretDone) mExl = 1'b0;
`ifdef IRQ_EDGE_LATCH_EN
        mPend    = (mPend & ~((we && addr == 5'd13) ? data[11:8] : 4'h0)) | (irq & ~mIrqPrev);
        mIrqPrev = irq;
`endif
        if (entered) mPhase = 1;
        else if (eretDone) mPhase = 3;
        else if (mPhase == 1) mPhase = 2;
        else if (mPhase == 3) mPhase = 0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic checkState();
        bit        expRedir = (mPhase == 1) || (mPhase == 3);
        bit [31:0] expPc    = (mPhase == 1) ? VEC : ((mPhase == 3) ? mEpc : 32'd0);
        bit        expTaken = (mPhase == 1) && mEntryInt;
        bit [31:0] expId    = expTaken ? 32'(mIntId) : 32'd0;
        checkOutput("redirect", 32'(redirect), 32'(expRedir));
        checkOutput("flush", 32'(flush), 32'(expRedir));
        checkOutput("redirect_pc", redirectPc, expPc);
        checkOutput("int_taken", 32'(intTaken), 32'(expTaken));
        checkOutput("int_id", 32'(intId), expId);
    endtask

    task automatic readReg(input logic [4:0] addr, input logic [31:0] expected, input string tag);
        c0Addr = addr;
        #1;
        checkOutput(tag, mfc0Data, expected);
    endtask

    // One clock of stimulus: check the combinational read, advance the model, check registered outputs.
    task automatic applyStimulus(input logic [3:0] irq, input logic exc, input logic [1:0] code,
                                 input logic [31:0] epc, input logic pcw, input logic eret,
                                 input logic we, input logic [4:0] addr, input logic [31:0] data);
        irqIn     = irq;
        excReq    = exc;
        excCode   = code;
        epcIn     = epc;
        pcIfWrite = pcw;
        eretIn    = eret;
        mtc0We    = we;
        c0Addr    = addr;
        mtc0Data  = data;
        #1;
        checkOutput("mfc0", mfc0Data, modelRead(addr, irq));
        modelStep(irq, exc, code, epc, pcw, eret, we, addr, data);
        @(posedge clk);
        #1;
        checkState();
    endtask

    initial begin
        bit          prevExc = 1'b0;
        logic [3:0]  rIrq    = 4'h0;
        logic        rExc;
        logic        rWe;
        logic [4:0]  rAddr;
        logic [31:0] rData;
        int          pick;

        rst = 1'b1;
        irqIn = 4'h0; excReq = 1'b0; excCode = 2'b00; epcIn = 32'd0; pcIfWrite = 1'b1;
        eretIn = 1'b0; mtc0We = 1'b0; c0Addr = 5'd0; mtc0Data = 32'd0;
        modelReset();
        @(posedge clk);
        #1;
        checkOutput("reset_redirect", 32'(redirect), 32'd0);
        checkOutput("reset_pc", redirectPc, 32'd0);
        checkOutput("reset_int_taken", 32'(intTaken), 32'd0);
        readReg(5'd12, 32'h0000_0F00, "reset_status");
        readReg(5'd13, 32'h0000_0000, "reset_cause");
        readReg(5'd14, 32'h0000_0000, "reset_epc");
        @(posedge clk);
        #1;
        rst = 1'b0;

`ifndef IRQ_EDGE_LATCH_EN
        $display("[TB] directed: interrupt entry, eret, retake");
        applyStimulus(4'h0, 0, 2'b00, 32'h0, 1, 0, 1, 5'd12, 32'h0000_0F01);
        applyStimulus(4'b0100, 0, 2'b00, 32'h0000_1234, 1, 0, 0, 5'd14, 32'h0);
        checkOutput("req036_pc", redirectPc, 32'h0000_0008);
        checkOutput("req036_id", 32'(intId), 32'd2);
        checkOutput("req036_taken", 32'(intTaken), 32'd1);
        readReg(5'd14, 32'h0000_1234, "req036_epc");
        readReg(5'd12, 32'h0000_0F03, "req036_exl");
        applyStimulus(4'b0100, 0, 2'b00, 32'h0, 1, 0, 0, 5'd12, 32'h0);
        applyStimulus(4'b0100, 0, 2'b00, 32'h0, 1, 1, 0, 5'd12, 32'h0);
        checkOutput("req038_pc", redirectPc, 32'h0000_1234);
        readReg(5'd12, 32'h0000_0F01, "req038_exl");
        applyStimulus(4'b0100, 0, 2'b00, 32'h0000_5678, 1, 0, 0, 5'd0, 32'h0);
        checkOutput("req038_return_done", 32'(redirect), 32'd0);
        applyStimulus(4'b0100, 0, 2'b00, 32'h0000_5678, 1, 0, 0, 5'd0, 32'h0);
        checkOutput("req038_retake", 32'(intTaken), 32'd1);
        applyStimulus(4'h0, 0, 2'b00, 32'h0, 1, 0, 0, 5'd0, 32'h0);
        applyStimulus(4'h0, 0, 2'b00, 32'h0, 1, 1, 0, 5'd0, 32'h0);
        applyStimulus(4'h0, 0, 2'b00, 32'h0, 1, 0, 0, 5'd0, 32'h0);

        $display("[TB] directed: exception beats interrupt");
        applyStimulus(4'b0011, 1, 2'b11, 32'h0000_2000, 1, 0, 0, 5'd13, 32'h0);
        checkOutput("req037_taken", 32'(intTaken), 32'd0);
        checkOutput("req037_redirect", 32'(redirect), 32'd1);
        readReg(5'd13, 32'h0000_030C, "req037_cause");
        readReg(5'd14, 32'h0000_2000, "req037_epc");
        applyStimulus(4'h0, 0, 2'b00, 32'h0, 1, 0, 0, 5'd0, 32'h0);
        applyStimulus(4'h0, 0, 2'b00, 32'h0, 1, 1, 0, 5'd0, 32'h0);
        applyStimulus(4'h0, 0, 2'b00, 32'h0, 1, 0, 0, 5'd0, 32'h0);

        $display("[TB] directed: stall blocks interrupt, then reset in vector cycle");
        applyStimulus(4'b0001, 0, 2'b00, 32'h0000_3000, 0, 0, 0, 5'd0, 32'h0);
        checkOutput("req039_stalled", 32'(redirect), 32'd0);
        applyStimulus(4'b0001, 0, 2'b00, 32'h0000_3004, 1, 0, 0, 5'd0, 32'h0);
        checkOutput("req039_taken", 32'(intTaken), 32'd1);
        checkOutput("req039_id", 32'(intId), 32'd0);
        rst = 1'b1;
        #1;
        checkOutput("req041_redirect", 32'(redirect), 32'd0);
        checkOutput("req041_flush", 32'(flush), 32'd0);
        checkOutput("req041_pc", redirectPc, 32'd0);
        checkOutput("req041_taken", 32'(intTaken), 32'd0);
        readReg(5'd12, 32'h0000_0F00, "req041_status");
        readReg(5'd13, 32'h0000_0000, "req041_cause");
        readReg(5'd14, 32'h0000_0000, "req041_epc");
        modelReset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(4'h0, 0, 2'b00, 32'h0, 1, 0, 0, 5'd0, 32'h0);
        checkOutput("req041_no_pulse", 32'(redirect), 32'd0);
`else
        $display("[TB] directed: edge-latched pending with write-1-to-clear");
        applyStimulus(4'h0, 0, 2'b00, 32'h0, 1, 0, 1, 5'd12, 32'h0000_0701);
        applyStimulus(4'b1000, 0, 2'b00, 32'h0, 1, 0, 0, 5'd13, 32'h0);
        applyStimulus(4'b0000, 0, 2'b00, 32'h0, 1, 0, 0, 5'd13, 32'h0);
        readReg(5'd13, 32'h0000_0800, "req040_set");
        checkOutput("req040_masked", 32'(redirect), 32'd0);
        applyStimulus(4'h0, 0, 2'b00, 32'h0, 1, 0, 1, 5'd13, 32'h0000_0800);
        readReg(5'd13, 32'h0000_0000, "req040_clear");
`endif

        $display("[TB] random traffic");
        for (int cyc = 0; cyc < 600; cyc++) begin
            if ($urandom_range(0, 3) == 0) rIrq = 4'($urandom);
            rExc = !prevExc && ($urandom_range(0, 9) == 0);
            prevExc = rExc;
            rWe = ($urandom_range(0, 6) == 0);
            pick = $urandom_range(0, 4);
            rAddr = (pick == 0) ? 5'd12 : (pick == 1) ? 5'd13 : (pick == 2) ? 5'd14 : 5'($urandom);
            rData = $urandom;
            if (rAddr == 5'd12) begin
                rData[0] = ($urandom_range(0, 4) != 0);
                rData[1] = ($urandom_range(0, 7) == 0);
            end
            applyStimulus(rIrq, rExc, 2'($urandom_range(1, 3)), $urandom & 32'hFFFF_FFFC,
                          ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0),
                          rWe, rAddr, rData);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
